// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution window generator: FSM encoding,
// kernel size and the row/column positions used to pack the window.
package conv_pkg;

    localparam int KERNEL_SIZE = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Row 0 is the oldest line, column 0 the oldest pixel of the window.
    localparam int ROW_OLDEST = 0;
    localparam int ROW_MIDDLE = 1;
    localparam int ROW_NEWEST = KERNEL_SIZE - 1;
    localparam int COL_OLDEST = 0;
    localparam int COL_NEWEST = KERNEL_SIZE - 1;

    function automatic logic [3:0] win_idx(input int r, input int c);
        return 4'(r * KERNEL_SIZE + c);
    endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel stream, frame configuration and window output bundle of conv_window_gen.
// cfg_stride2_i exists only when CONV_WINDOW_STRIDE2_EN is defined.
interface conv_window_gen_if #(
    parameter int KERNEL_DATA_WIDTH = 8,
    parameter int CNT_WIDTH         = 9
) ();

    logic                           start_i;
    logic [CNT_WIDTH-1:0]           cfg_width_i;
    logic [CNT_WIDTH-1:0]           cfg_height_i;
`ifdef CONV_WINDOW_STRIDE2_EN
    logic                           cfg_stride2_i;
`endif
    logic                           pix_valid_i;
    logic [KERNEL_DATA_WIDTH-1:0]   pix_data_i;
    logic                           pix_ready_o;
    logic                           pipe_flush_o;
    logic                           kernel_data_valid_o;
    logic [9*KERNEL_DATA_WIDTH-1:0] kernel_data_o;
    logic                           frame_done_o;
    logic                           cfg_err_o;

    modport master (
`ifdef CONV_WINDOW_STRIDE2_EN
        output cfg_stride2_i,
`endif
        output start_i, cfg_width_i, cfg_height_i, pix_valid_i, pix_data_i,
        input  pix_ready_o, pipe_flush_o, kernel_data_valid_o, kernel_data_o,
               frame_done_o, cfg_err_o
    );

    modport slave (
`ifdef CONV_WINDOW_STRIDE2_EN
        input  cfg_stride2_i,
`endif
        input  start_i, cfg_width_i, cfg_height_i, pix_valid_i, pix_data_i,
        output pix_ready_o, pipe_flush_o, kernel_data_valid_o, kernel_data_o,
               frame_done_o, cfg_err_o
    );

endinterface

// File: rtl/conv_line_buffer.sv
// Single-port line memory with combinational read: the old entry is visible
// in the same cycle it is overwritten (read-before-write).
module conv_line_buffer #(
    parameter int DEPTH      = 224,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rdata_o = mem[addr_i];

    // NOTE: no reset on the storage array; stale entries are always rewritten
    // in the current frame before any window using them can become valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streams a raster frame through two line buffers and emits sliding 3x3 windows.
// Define CONV_WINDOW_STRIDE2_EN to add cfg_stride2_i (stride-2 window output).
module conv_window_gen #(
    parameter int KERNEL_SIZE       = 3,
    parameter int KERNEL_DATA_WIDTH = 8,
    parameter int MAX_WIDTH         = 224,
    parameter int CNT_WIDTH         = 9
) (
    input logic              clk,
    input logic              rst_n,
    conv_window_gen_if.slave bus
);
    import conv_pkg::*;

    localparam int WIN_N = KERNEL_SIZE * KERNEL_SIZE;
    localparam int LB_AW = $clog2(MAX_WIDTH);
    localparam logic [CNT_WIDTH-1:0] K_MIN  = CNT_WIDTH'(KERNEL_SIZE);
    localparam logic [CNT_WIDTH-1:0] K_LAST = CNT_WIDTH'(KERNEL_SIZE - 1);

    logic [1:0]                              state_q, state_d;
    logic [CNT_WIDTH-1:0]                    width_q, width_d;
    logic [CNT_WIDTH-1:0]                    height_q, height_d;
    logic [CNT_WIDTH-1:0]                    col_q, col_d;
    logic [CNT_WIDTH-1:0]                    row_q, row_d;
    logic                                    flush_q, flush_d;
    logic                                    cfg_err_q, cfg_err_d;
    logic                                    win_valid_q, win_valid_d;
    logic [WIN_N-1:0][KERNEL_DATA_WIDTH-1:0] win_q, win_d;

    logic                         accept;
    logic                         cfg_ok;
    logic                         last_col;
    logic                         last_row;
    logic                         stride_ok;
    logic                         win_hit;
    logic [KERNEL_DATA_WIDTH-1:0] lb1_rdata;
    logic [KERNEL_DATA_WIDTH-1:0] lb2_rdata;

    assign accept   = bus.pix_valid_i && (state_q == ST_RUN);
    assign cfg_ok   = (bus.cfg_width_i >= K_MIN) &&
                      (bus.cfg_width_i <= CNT_WIDTH'(MAX_WIDTH)) &&
                      (bus.cfg_height_i >= K_MIN);
    assign last_col = (col_q == width_q - 1'b1);
    assign last_row = (row_q == height_q - 1'b1);

`ifdef CONV_WINDOW_STRIDE2_EN
    logic stride2_q, stride2_d;

    assign stride_ok = !stride2_q || (!row_q[0] && !col_q[0]);
    assign stride2_d = (state_q == ST_IDLE && bus.start_i && cfg_ok) ? bus.cfg_stride2_i
                                                                     : stride2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stride2_q <= 1'b0;
        end else begin
            stride2_q <= stride2_d;
        end
    end
`else
    assign stride_ok = 1'b1;
`endif

    // Windows that would straddle a line wrap are excluded by the row/col floor.
    assign win_hit = (row_q >= K_LAST) && (col_q >= K_LAST) && stride_ok;

    // line1 holds the previous row, line2 the row before it.
    conv_line_buffer #(
        .DEPTH     (MAX_WIDTH),
        .DATA_WIDTH(KERNEL_DATA_WIDTH),
        .ADDR_WIDTH(LB_AW)
    ) u_line1 (
        .clk    (clk),
        .we_i   (accept),
        .addr_i (col_q[LB_AW-1:0]),
        .wdata_i(bus.pix_data_i),
        .rdata_o(lb1_rdata)
    );

    conv_line_buffer #(
        .DEPTH     (MAX_WIDTH),
        .DATA_WIDTH(KERNEL_DATA_WIDTH),
        .ADDR_WIDTH(LB_AW)
    ) u_line2 (
        .clk    (clk),
        .we_i   (accept),
        .addr_i (col_q[LB_AW-1:0]),
        .wdata_i(lb1_rdata),
        .rdata_o(lb2_rdata)
    );

    // NOTE: every signal gets a default at the top so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        width_d     = width_q;
        height_d    = height_q;
        col_d       = col_q;
        row_d       = row_q;
        flush_d     = 1'b0;
        cfg_err_d   = 1'b0;
        win_valid_d = 1'b0;
        win_d       = win_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    if (cfg_ok) begin
                        width_d  = bus.cfg_width_i;
                        height_d = bus.cfg_height_i;
                        col_d    = '0;
                        row_d    = '0;
                        flush_d  = 1'b1;
                        state_d  = ST_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                        if (last_row) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end

                    for (int r = ROW_OLDEST; r <= ROW_NEWEST; r++) begin
                        for (int c = COL_OLDEST; c < COL_NEWEST; c++) begin
                            win_d[win_idx(r, c)] = win_q[win_idx(r, c + 1)];
                        end
                    end
                    win_d[win_idx(ROW_OLDEST, COL_NEWEST)] = lb2_rdata;
                    win_d[win_idx(ROW_MIDDLE, COL_NEWEST)] = lb1_rdata;
                    win_d[win_idx(ROW_NEWEST, COL_NEWEST)] = bus.pix_data_i;

                    win_valid_d = win_hit;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops see
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            flush_q     <= 1'b0;
            cfg_err_q   <= 1'b0;
            win_valid_q <= 1'b0;
            win_q       <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            col_q       <= col_d;
            row_q       <= row_d;
            flush_q     <= flush_d;
            cfg_err_q   <= cfg_err_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
        end
    end

    assign bus.pix_ready_o         = (state_q == ST_RUN);
    assign bus.pipe_flush_o        = flush_q;
    assign bus.kernel_data_valid_o = win_valid_q;
    assign bus.kernel_data_o       = win_q;
    assign bus.frame_done_o        = (state_q == ST_DONE);
    assign bus.cfg_err_o           = cfg_err_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized self-checking bench for conv_window_gen; the reference model rebuilds
// every expected window directly from the stored frame image.
module tb_conv_window_gen;

    localparam int DW   = 8;
    localparam int CW   = 9;
    localparam int MAXW = 224;
    localparam int WB   = 9 * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    conv_window_gen_if #(.KERNEL_DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    conv_window_gen #(
        .KERNEL_SIZE      (3),
        .KERNEL_DATA_WIDTH(DW),
        .MAX_WIDTH        (MAXW),
        .CNT_WIDTH        (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Reference model: 0 idle, 1 run, 2 done
    int            m_state    = 0;
    int            cur_w      = 0;
    int            cur_h      = 0;
    bit            cur_stride = 1'b0;
    bit            stride_req = 1'b0;
    int            acc_count  = 0;
    int            win_seen   = 0;
    bit            first_seen = 1'b0;
    logic [WB-1:0] first_win  = '0;
    logic [DW-1:0] img [];

    task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus: predict from the pre-edge inputs, then compare #1 after the edge.
    task automatic step();
        bit            legal, illegal, acc, exp_valid, cfg_ok;
        int            nw, nh, r, c;
        logic [WB-1:0] exp_win;
        nw        = int'(bus.cfg_width_i);
        nh        = int'(bus.cfg_height_i);
        cfg_ok    = (nw >= 3) && (nw <= MAXW) && (nh >= 3);
        legal     = bus.start_i && (m_state == 0) && cfg_ok;
        illegal   = bus.start_i && (m_state == 0) && !cfg_ok;
        acc       = bus.pix_valid_i && (m_state == 1);
        exp_valid = 1'b0;
        exp_win   = '0;
        @(posedge clk);
        #1;
        if (m_state == 2) m_state = 0;
        if (legal) begin
            m_state    = 1;
            cur_w      = nw;
            cur_h      = nh;
            cur_stride = stride_req;
            acc_count  = 0;
            win_seen   = 0;
            first_seen = 1'b0;
        end
        if (acc) begin
            r = acc_count / cur_w;
            c = acc_count % cur_w;
            exp_valid = (r >= 2) && (c >= 2) && (!cur_stride || ((r % 2 == 0) && (c % 2 == 0)));
            if (exp_valid) begin
                for (int k = 0; k < 9; k++) begin
                    exp_win[k*DW +: DW] = img[(r - 2 + k / 3) * cur_w + (c - 2 + k % 3)];
                end
            end
            acc_count++;
            if (acc_count == cur_w * cur_h) m_state = 2;
        end
        check("pipe_flush", bus.pipe_flush_o, legal);
        check("cfg_err", bus.cfg_err_o, illegal);
        check("pix_ready", bus.pix_ready_o, m_state == 1);
        check("frame_done", bus.frame_done_o, m_state == 2);
        check("win_valid", bus.kernel_data_valid_o, exp_valid);
        if (exp_valid) check("win_data", bus.kernel_data_o, exp_win);
        if (bus.kernel_data_valid_o === 1'b1) begin
            win_seen++;
            if (!first_seen) begin
                first_win  = bus.kernel_data_o;
                first_seen = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        bus.start_i     = 1'b0;
        bus.pix_valid_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        m_state    = 0;
        acc_count  = 0;
        check("rst_ready", bus.pix_ready_o, 1'b0);
        check("rst_flush", bus.pipe_flush_o, 1'b0);
        check("rst_valid", bus.kernel_data_valid_o, 1'b0);
        check("rst_done", bus.frame_done_o, 1'b0);
        check("rst_err", bus.cfg_err_o, 1'b0);
        check("rst_data", bus.kernel_data_o, '0);
    endtask

    // gap_mode: 0 continuous, 1 alternate 1/0, 2 random. abort_after/start_poke < 0 disables.
    task automatic run_frame(input int w, input int h, input bit stride, input int gap_mode,
                             input bit seq_pix, input int abort_after, input int start_poke);
        bit toggle, poked, v;
        int exp_cnt;
        img = new[w * h];
        for (int i = 0; i < w * h; i++) img[i] = seq_pix ? DW'(i) : DW'($urandom);
        bus.cfg_width_i  = CW'(w);
        bus.cfg_height_i = CW'(h);
        stride_req       = stride;
`ifdef CONV_WINDOW_STRIDE2_EN
        bus.cfg_stride2_i = stride;
`endif
        bus.start_i     = 1'b1;
        bus.pix_valid_i = 1'b0;
        step();
        bus.start_i = 1'b0;
        toggle = 1'b1;
        poked  = 1'b0;
        for (int n = 0; n < 8000 && m_state == 1; n++) begin
            if (abort_after >= 0 && acc_count == abort_after) break;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = toggle;
                default: v = 1'($urandom_range(0, 1));
            endcase
            toggle          = !toggle;
            bus.pix_valid_i = v;
            bus.pix_data_i  = v ? img[acc_count] : DW'($urandom);
            if (!poked && start_poke >= 0 && acc_count == start_poke) begin
                poked            = 1'b1;
                bus.start_i      = 1'b1;
                bus.cfg_width_i  = CW'(3);
                bus.cfg_height_i = CW'(3);
            end
            step();
            bus.start_i      = 1'b0;
            bus.cfg_width_i  = CW'(w);
            bus.cfg_height_i = CW'(h);
        end
        bus.pix_valid_i = 1'b0;
        if (abort_after >= 0) begin
            do_reset();
            step();
            return;
        end
        exp_cnt = stride ? ((w - 1) / 2) * ((h - 1) / 2) : (w - 2) * (h - 2);
        check("win_count", win_seen, exp_cnt);
        step();
        step();
    endtask

    task automatic try_illegal(input int w, input int h);
        bus.cfg_width_i  = CW'(w);
        bus.cfg_height_i = CW'(h);
        bus.start_i      = 1'b1;
        bus.pix_valid_i  = 1'b1;
        bus.pix_data_i   = DW'($urandom);
        step();
        bus.start_i = 1'b0;
        step();
        step();
        bus.pix_valid_i = 1'b0;
    endtask

    initial begin
        logic [WB-1:0] ref_first;
        int            first_vals [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        bus.start_i      = 1'b0;
        bus.cfg_width_i  = '0;
        bus.cfg_height_i = '0;
        bus.pix_valid_i  = 1'b0;
        bus.pix_data_i   = '0;
`ifdef CONV_WINDOW_STRIDE2_EN
        bus.cfg_stride2_i = 1'b0;
`endif
        @(posedge clk);
        #1;
        do_reset();

        // 4x4 frame of pixels 0..15, continuous
        run_frame(4, 4, 1'b0, 0, 1'b1, -1, -1);
        for (int k = 0; k < 9; k++) ref_first[k*DW +: DW] = DW'(first_vals[k]);
        check("first_window", first_win, ref_first);

        // 5x3 with alternating valid gaps
        run_frame(5, 3, 1'b0, 1, 1'b0, -1, -1);

        // illegal configurations, then the legal boundaries
        try_illegal(2, 4);
        try_illegal(4, 0);
        try_illegal(MAXW + 1, 3);
        run_frame(3, 3, 1'b0, 0, 1'b0, -1, -1);
        run_frame(MAXW, 3, 1'b0, 2, 1'b0, -1, -1);

        // reset after 7 pixels, then a clean 4x4 frame
        run_frame(4, 4, 1'b0, 0, 1'b0, 7, -1);
        run_frame(4, 4, 1'b0, 0, 1'b0, -1, -1);

        // start_i pulsed mid-frame must be ignored
        run_frame(6, 4, 1'b0, 0, 1'b0, -1, 5);

        for (int t = 0; t < 6; t++) begin
            run_frame(int'($urandom_range(3, 12)), int'($urandom_range(3, 8)),
                      1'b0, 2, 1'b0, -1, -1);
        end

`ifdef CONV_WINDOW_STRIDE2_EN
        // stride 2 on 6x6: first window is centred at (1,1), i.e. rows 0..2 cols 0..2
        run_frame(6, 6, 1'b1, 0, 1'b1, -1, -1);
        for (int k = 0; k < 9; k++) ref_first[k*DW +: DW] = DW'((k / 3) * 6 + (k % 3));
        check("stride2_first_window", first_win, ref_first);
        run_frame(int'($urandom_range(3, 11)), int'($urandom_range(3, 9)),
                  1'b1, 2, 1'b0, -1, -1);
        stride_req = 1'b0;
        bus.cfg_stride2_i = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
